// File: rtl/envelope_gate.sv
// envelope_gate: ADSR amplitude envelope applied to a 1-bit tone as a PWM duty cycle.
// Ports: clk, reset (sync, active-high), signal_in, gate, attack/decay/release
//        rates, sustain_level in; audio_out (PWM-gated tone), level, busy out.
module envelope_gate #(
    parameter int unsigned CLK_DIV  = 25000,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                signal_in,
    input  logic                gate,
    input  logic [3:0]          attack_rate,
    input  logic [3:0]          decay_rate,
    input  logic [PWM_BITS-1:0] sustain_level,
    input  logic [3:0]          release_rate,
    output logic                audio_out,
    output logic [PWM_BITS-1:0] level,
    output logic                busy
);

    localparam int unsigned W  = PWM_BITS;
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
    localparam logic [W-1:0]  LVL_MAX   = {W{1'b1}};
    localparam logic [W-1:0]  LVL_ZERO  = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  level_q, level_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [W-1:0]  pwm_q, pwm_d;
    logic          gate_dly_q;
    logic          audio_q, audio_d;
    logic          busy_q;

    logic          tick;
    logic          rise;
    logic          fall;

    // One extra bit on every step/sum so carries and borrows are visible
    logic [W:0]    step_a, step_d, step_r;
    logic [W:0]    sum_a;
    logic [W:0]    diff_d;
    logic [W:0]    diff_r;
    logic          a_sat;
    logic          d_reach;
    logic          r_empty;

    // ---------------------------------------------------------------
    // Tick divider and gate edge detection
    // ---------------------------------------------------------------
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + CW'(1);
        if (tick) begin
            tick_cnt_d = '0;
        end
    end

    assign rise = gate & ~gate_dly_q;
    assign fall = ~gate & gate_dly_q;

    // ---------------------------------------------------------------
    // Saturating level arithmetic
    // ---------------------------------------------------------------
    assign step_a = {{(W-3){1'b0}}, attack_rate}  + (W+1)'(1);
    assign step_d = {{(W-3){1'b0}}, decay_rate}   + (W+1)'(1);
    assign step_r = {{(W-3){1'b0}}, release_rate} + (W+1)'(1);

    assign sum_a  = {1'b0, level_q} + step_a;
    assign diff_d = {1'b0, level_q} - step_d;
    assign diff_r = {1'b0, level_q} - step_r;

    // Carry out or an exact all-ones result both mean full scale
    assign a_sat = sum_a[W] | (&sum_a[W-1:0]);

    // A borrow (top bit set) means the step went below zero
    assign d_reach = (sustain_level >= level_q)
                   | diff_d[W]
                   | (diff_d[W-1:0] <= sustain_level);

    assign r_empty = diff_r[W] | (diff_r[W-1:0] == LVL_ZERO);

    // ---------------------------------------------------------------
    // Envelope state machine
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        level_d = level_q;

        unique case (state_q)
            S_IDLE: begin
                level_d = LVL_ZERO;
                if (rise) begin
                    state_d = S_ATTACK;
                end
            end

            S_ATTACK: begin
                if (fall) begin
                    state_d = S_RELEASE;
                end else if (tick) begin
                    if (a_sat) begin
                        level_d = LVL_MAX;
                        state_d = S_DECAY;
                    end else begin
                        level_d = sum_a[W-1:0];
                    end
                end
            end

            S_DECAY: begin
                if (fall) begin
                    state_d = S_RELEASE;
                end else if (tick) begin
                    if (d_reach) begin
                        level_d = sustain_level;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = diff_d[W-1:0];
                    end
                end
            end

            S_SUSTAIN: begin
                // Level held on the release edge, otherwise tracks live sustain
                if (fall) begin
                    state_d = S_RELEASE;
                end else begin
                    level_d = sustain_level;
                end
            end

            S_RELEASE: begin
                // Retrigger restarts attack from the current level
                if (rise) begin
                    state_d = S_ATTACK;
                end else if (tick) begin
                    if (r_empty) begin
                        level_d = LVL_ZERO;
                        state_d = S_IDLE;
                    end else begin
                        level_d = diff_r[W-1:0];
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                level_d = LVL_ZERO;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // PWM modulation of the tone
    // ---------------------------------------------------------------
    assign pwm_d   = pwm_q + W'(1);
    assign audio_d = signal_in & (pwm_q < level_q);

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            level_q    <= LVL_ZERO;
            tick_cnt_q <= '0;
            pwm_q      <= '0;
            gate_dly_q <= 1'b0;
            audio_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            tick_cnt_q <= tick_cnt_d;
            pwm_q      <= pwm_d;
            gate_dly_q <= gate;
            audio_q    <= audio_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign audio_out = audio_q;
    assign level     = level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_envelope_gate.sv
// tb_envelope_gate: randomized and directed checks of envelope_gate against
// an integer-arithmetic ADSR reference model.
module tb_envelope_gate;

    localparam int DIV = 4;

    localparam int P_OFF  = 0;
    localparam int P_UP   = 1;
    localparam int P_DOWN = 2;
    localparam int P_HOLD = 3;
    localparam int P_FADE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       signal_in;
    logic       gate;
    logic [3:0] ar, dr, rr;
    logic [7:0] sl;
    logic       audio_out;
    logic [7:0] level;
    logic       busy;

    int n_run  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // reference model state
    int m_lvl  = 0;
    int m_ph   = P_OFF;
    int m_cnt  = 0;
    int m_pwm  = 0;
    int m_aud  = 0;
    int m_busy = 0;
    int m_gp   = 0;
    int m_tk, m_rise, m_fall;

    always #5 clk = ~clk;

    envelope_gate #(.CLK_DIV(DIV), .PWM_BITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .signal_in    (signal_in),
        .gate         (gate),
        .attack_rate  (ar),
        .decay_rate   (dr),
        .sustain_level(sl),
        .release_rate (rr),
        .audio_out    (audio_out),
        .level        (level),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // ADSR model: plain integer min/max on the level, one step per tick
    always @(posedge clk) begin
        if (reset) begin
            m_lvl = 0; m_ph = P_OFF; m_cnt = 0; m_pwm = 0;
            m_aud = 0; m_busy = 0; m_gp = 0;
        end else begin
            m_tk   = (m_cnt == DIV - 1) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % DIV;
            m_aud  = (signal_in && (m_pwm < m_lvl)) ? 1 : 0;
            m_pwm  = (m_pwm + 1) % 256;
            m_rise = (gate && !m_gp) ? 1 : 0;
            m_fall = (!gate && m_gp) ? 1 : 0;
            m_gp   = gate ? 1 : 0;
            if (m_ph == P_OFF) begin
                m_lvl = 0;
                if (m_rise != 0) m_ph = P_UP;
            end else if (m_ph == P_FADE) begin
                if (m_rise != 0) m_ph = P_UP;
                else if (m_tk != 0) begin
                    m_lvl = imax(m_lvl - int'(rr) - 1, 0);
                    if (m_lvl == 0) m_ph = P_OFF;
                end
            end else if (m_fall != 0) begin
                m_ph = P_FADE;
            end else if (m_ph == P_HOLD) begin
                m_lvl = int'(sl);
            end else if (m_tk != 0) begin
                if (m_ph == P_UP) begin
                    m_lvl = imin(m_lvl + int'(ar) + 1, 255);
                    if (m_lvl == 255) m_ph = P_DOWN;
                end else begin
                    m_lvl = imax(m_lvl - int'(dr) - 1, int'(sl));
                    if (m_lvl == int'(sl)) m_ph = P_HOLD;
                end
            end
            m_busy = (m_ph != P_OFF) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", level, m_lvl);
            chk("busy", busy, m_busy);
            chk("audio", audio_out, m_aud);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_lvl(input string tag, input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (level == 8'(target)) break;
            @(negedge clk);
        end
        chk(tag, level, target);
    endtask

    initial begin
        int cnt;
        int hold;
        reset     = 1'b1;
        gate      = 1'b1;
        signal_in = 1'b1;
        ar = 4'd15; dr = 4'd0; rr = 4'd3; sl = 8'd128;

        @(posedge clk);
        #1 chk_en = 1'b1;

        // reset held with gate and tone high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_level", level, 0);
            chk("rst_busy", busy, 0);
            chk("rst_audio", audio_out, 0);
        end
        reset = 1'b0;
        gate  = 1'b0;
        cyc(1);

        // attack to full scale, decay to sustain 128
        gate = 1'b1;
        cyc(1);
        chk("atk_busy", busy, 1);
        wait_lvl("atk_peak", 255, 100);
        wait_lvl("dec_sus", 128, 127 * DIV + 20);
        sl = 8'd100;
        cyc(1);
        chk("sus_track", level, 100);
        sl = 8'd128;
        cyc(1);

        // release by 4 per tick down to idle
        gate = 1'b0;
        wait_lvl("rel_zero", 0, 32 * DIV + 20);
        chk("rel_busy", busy, 0);

        // sustain at 64 for the PWM duty check
        ar = 4'd15; dr = 4'd15; sl = 8'd64;
        gate = 1'b1;
        wait_lvl("pwm_peak", 255, 100);
        wait_lvl("pwm_sus", 64, 100);
        cyc(2);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt += int'(audio_out);
        end
        chk("pwm_64", cnt, 64);
        signal_in = 1'b0;
        cyc(1);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt += int'(audio_out);
        end
        chk("pwm_off", cnt, 0);
        signal_in = 1'b1;

        // retrigger from release at level 100
        sl = 8'd100; ar = 4'd4;
        cyc(2);
        chk("rtg_sus", level, 100);
        gate = 1'b0;
        cyc(1);
        gate = 1'b1;
        cyc(1);
        chk("rtg_hold", level, 100);
        for (int i = 0; i < 20; i++) begin
            if (level != 8'd100) break;
            @(negedge clk);
        end
        chk("rtg_step", level, 105);

        // reset in the middle of attack
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        gate  = 1'b0;
        cyc(1);

        // randomized gate patterns, rates and tone
        for (int it = 0; it < 50; it++) begin
            ar = 4'($urandom);
            dr = 4'($urandom);
            rr = 4'($urandom);
            sl = 8'($urandom);
            gate = ~gate;
            reset = ($urandom_range(0, 19) == 0);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                               : $urandom_range(10, 90);
            for (int k = 0; k < hold; k++) begin
                signal_in = 1'($urandom);
                if ($urandom_range(0, 31) == 0) sl = 8'($urandom);
                cyc(1);
                reset = 1'b0;
            end
        end
        cyc(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
